// File: rtl/simd_operand_packer.sv
// rtl/simd_operand_packer.sv - packs narrow operand lanes into 54-bit SIMD multiplier words
// Optional idle force-flush of partial words: define SIMD_PACKER_TIMEOUT_EN.
module simd_operand_packer #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mode,
    input  logic        a_sign,
    input  logic        b_sign,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [26:0] in_a,
    input  logic [17:0] in_b,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [53:0] a,
    output logic [53:0] b,
    output logic [1:0]  out_mode,
    output logic        out_a_sign,
    output logic        out_b_sign,
    output logic [4:0]  out_lanes
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [53:0] pk_a;
    logic [53:0] pk_b;
    logic [4:0]  cnt;
    logic [1:0]  pk_mode;
    logic        pk_a_sign;
    logic        pk_b_sign;

    logic        beat;
    logic        done;
    logic        out_free;
    logic        tmo_hit;
    logic        xfer;
    logic [1:0]  eff_mode;
    logic [4:0]  lane_n;
    logic [5:0]  sh;
    logic [53:0] lane_a;
    logic [53:0] lane_b;
    logic [53:0] word_a;
    logic [53:0] word_b;
    logic [1:0]  word_mode;
    logic        word_a_sign;
    logic        word_b_sign;
    logic [4:0]  word_lanes;

    assign in_ready = (state != HOLD);
    assign beat     = in_valid & in_ready;
    assign out_free = ~out_valid | out_ready;
    // Mode and signs come from the port only on the first beat of a word.
    assign eff_mode = (state == EMPTY) ? mode : pk_mode;

    always_comb begin
        lane_a = '0;
        lane_b = '0;
        lane_n = 5'd1;
        sh     = 6'd0;
        case (eff_mode)
            2'b00: begin
                lane_a = {27'b0, in_a};
                lane_b = {36'b0, in_b};
            end
            2'b01: begin
                lane_n = 5'd6;
                sh     = 6'(9 * cnt);
                lane_a = {45'b0, in_a[8:0]} << sh;
                lane_b = {45'b0, in_b[8:0]} << sh;
            end
            2'b10: begin
                lane_n = 5'd12;
                sh     = 6'(9 * (cnt / 2) + 5 * (cnt % 2));
                lane_a = {50'b0, in_a[3:0]} << sh;
                lane_b = {50'b0, in_b[3:0]} << sh;
            end
            default: begin
                lane_n = 5'd18;
                sh     = 6'(9 * (cnt / 3) + 3 * (cnt % 3));
                lane_a = {52'b0, in_a[1:0]} << sh;
                lane_b = {52'b0, in_b[1:0]} << sh;
            end
        endcase
    end

    assign done = beat & (in_last | ((cnt + 5'd1) == lane_n));

`ifdef SIMD_PACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == FILLING && !beat && tmo_cnt != TW'(TIMEOUT)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (state == FILLING) & ~beat & (tmo_cnt == TW'(TIMEOUT));
`else
    // TIMEOUT only matters when the flush counter is built.
    assign tmo_hit = 1'b0 & (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        xfer      = 1'b0;
        case (state)
            EMPTY, FILLING: begin
                if (done || tmo_hit) begin
                    xfer      = out_free;
                    state_nxt = out_free ? EMPTY : HOLD;
                end else if (beat) begin
                    state_nxt = FILLING;
                end
            end
            HOLD: begin
                if (out_free) begin
                    xfer      = 1'b1;
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // The word handed to the output register includes the lane arriving this edge.
    assign word_a      = beat ? (pk_a | lane_a) : pk_a;
    assign word_b      = beat ? (pk_b | lane_b) : pk_b;
    assign word_mode   = eff_mode;
    assign word_a_sign = (state == EMPTY) ? a_sign : pk_a_sign;
    assign word_b_sign = (state == EMPTY) ? b_sign : pk_b_sign;
    assign word_lanes  = beat ? (cnt + 5'd1) : cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pk_a      <= '0;
            pk_b      <= '0;
            cnt       <= '0;
            pk_mode   <= '0;
            pk_a_sign <= 1'b0;
            pk_b_sign <= 1'b0;
        end else if (xfer) begin
            pk_a      <= '0;
            pk_b      <= '0;
            cnt       <= '0;
            pk_mode   <= '0;
            pk_a_sign <= 1'b0;
            pk_b_sign <= 1'b0;
        end else if (beat) begin
            pk_a      <= word_a;
            pk_b      <= word_b;
            cnt       <= word_lanes;
            pk_mode   <= word_mode;
            pk_a_sign <= word_a_sign;
            pk_b_sign <= word_b_sign;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            a          <= '0;
            b          <= '0;
            out_mode   <= '0;
            out_a_sign <= 1'b0;
            out_b_sign <= 1'b0;
            out_lanes  <= '0;
        end else if (xfer) begin
            out_valid  <= 1'b1;
            a          <= word_a;
            b          <= word_b;
            out_mode   <= word_mode;
            out_a_sign <= word_a_sign;
            out_b_sign <= word_b_sign;
            out_lanes  <= word_lanes;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_simd_operand_packer.sv
// tb/tb_simd_operand_packer.sv - randomized bench for simd_operand_packer against a lane-queue model
module tb_simd_operand_packer;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = '0;
    logic        a_sign = 1'b0;
    logic        b_sign = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [26:0] in_a = '0;
    logic [17:0] in_b = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [53:0] a;
    logic [53:0] b;
    logic [1:0]  out_mode;
    logic        out_a_sign;
    logic        out_b_sign;
    logic [4:0]  out_lanes;

    simd_operand_packer #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .a_sign(a_sign), .b_sign(b_sign),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .out_mode(out_mode), .out_a_sign(out_a_sign),
        .out_b_sign(out_b_sign), .out_lanes(out_lanes)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: lanes of the open word, one completed-but-waiting word, output register.
    logic [26:0] q_a[$];
    logic [17:0] q_b[$];
    logic [1:0]  c_mode;
    logic        c_as, c_bs;
    bit          held;
    logic [53:0] h_a, h_b;
    logic [1:0]  h_mode;
    logic        h_as, h_bs;
    int          h_lanes;
    bit          m_ov;
    logic [53:0] m_a, m_b;
    logic [1:0]  m_mode;
    logic        m_as, m_bs;
    int          m_lanes;
    int          idle;

    function automatic int lanes_of(input logic [1:0] m);
        case (m)
            2'd0: return 1;
            2'd1: return 6;
            2'd2: return 12;
            default: return 18;
        endcase
    endfunction

    function automatic int width_of(input logic [1:0] m, input bit is_a);
        case (m)
            2'd0: return is_a ? 27 : 18;
            2'd1: return 9;
            2'd2: return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int lane_pos(input logic [1:0] m, input int j);
        case (m)
            2'd0: return 0;
            2'd1: return 9 * j;
            2'd2: return 9 * (j / 2) + 5 * (j % 2);
            default: return 9 * (j / 3) + 3 * (j % 3);
        endcase
    endfunction

    function automatic logic [53:0] pack(input logic [1:0] m, input bit is_a);
        logic [53:0] acc;
        logic [63:0] v;
        int w;
        acc = '0;
        w = width_of(m, is_a);
        for (int j = 0; j < q_a.size(); j++) begin
            v = is_a ? 64'(q_a[j]) : 64'(q_b[j]);
            v = v & ((64'd1 << w) - 64'd1);
            acc = acc | 54'(v << lane_pos(m, j));
        end
        return acc;
    endfunction

    task automatic model_clear();
        q_a.delete();
        q_b.delete();
        held = 0;
        m_ov = 0;
        idle = 0;
    endtask

    task automatic model_step();
        bit free, beat, done;
        free = !m_ov || out_ready;
        beat = in_valid && !held;
        done = 0;
        if (beat) begin
            if (q_a.size() == 0) begin
                c_mode = mode;
                c_as = a_sign;
                c_bs = b_sign;
            end
            q_a.push_back(in_a);
            q_b.push_back(in_b);
            idle = 0;
            done = in_last || (q_a.size() == lanes_of(c_mode));
        end
`ifdef SIMD_PACKER_TIMEOUT_EN
        else if (!held && q_a.size() > 0) begin
            if (idle == TIMEOUT) done = 1;
            else idle++;
        end
`endif
        if (done) begin
            held = 1;
            h_a = pack(c_mode, 1);
            h_b = pack(c_mode, 0);
            h_mode = c_mode;
            h_as = c_as;
            h_bs = c_bs;
            h_lanes = q_a.size();
            q_a.delete();
            q_b.delete();
            idle = 0;
        end
        if (held && free) begin
            m_ov = 1;
            m_a = h_a;
            m_b = h_b;
            m_mode = h_mode;
            m_as = h_as;
            m_bs = h_bs;
            m_lanes = h_lanes;
            held = 0;
        end else if (out_ready) begin
            m_ov = 0;
        end
    endtask

    task automatic compare_outputs();
        check("in_ready", in_ready, !held);
        check("out_valid", out_valid, m_ov);
        if (m_ov) begin
            check("a", a, m_a);
            check("b", b, m_b);
            check("out_mode", out_mode, m_mode);
            check("out_a_sign", out_a_sign, m_as);
            check("out_b_sign", out_b_sign, m_bs);
            check("out_lanes", out_lanes, m_lanes);
        end
    endtask

    task automatic step(input bit v, input logic [1:0] md, input bit as, input bit bs,
                        input logic [26:0] ia, input logic [17:0] ib, input bit l, input bit ordy);
        in_valid = v;
        mode = md;
        a_sign = as;
        b_sign = bs;
        in_a = ia;
        in_b = ib;
        in_last = l;
        out_ready = ordy;
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle_step(input bit ordy);
        step(0, 2'($urandom), 1'($urandom), 1'($urandom), 27'($urandom), 18'($urandom), 0, ordy);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check("rst_out_valid", out_valid, 0);
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_lanes", out_lanes, 0);
        check("rst_out_mode", out_mode, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [53:0] exp_w;
    int k;

    initial begin
        model_clear();
        #12;
        check("por_out_valid", out_valid, 0);
        check("por_a", a, 0);
        check("por_b", b, 0);
        check("por_in_ready", in_ready, 1);
        check("por_out_lanes", out_lanes, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 9x9 partial word discarded by reset, then a clean 6-lane word
        for (int j = 0; j < 3; j++) step(1, 2'd1, 1, 0, 27'($urandom), 18'($urandom), 0, 1);
        async_reset();
        for (int j = 1; j <= 6; j++) step(1, 2'd1, 1, 1, 27'(j), 18'h1FF, 0, 1);
        exp_w = {9'd6, 9'd5, 9'd4, 9'd3, 9'd2, 9'd1};
        check("9x9_a", a, exp_w);
        check("9x9_b", b, {6{9'h1FF}});
        check("9x9_mode", out_mode, 2'b01);
        check("9x9_lanes", out_lanes, 6);

        // 27x18 full-scale stream, one word per cycle
        for (int j = 0; j < 4; j++) begin
            step(1, 2'd0, 0, 1, 27'h7FFFFFF, 18'h3FFFF, 0, 1);
            check("27x18_valid", out_valid, 1);
            check("27x18_a", a, 54'h7FFFFFF);
            check("27x18_b", b, 54'h3FFFF);
        end

        // 4x4 short word closed by in_last on lane 2
        for (int j = 0; j < 3; j++) step(1, 2'd2, 0, 0, 27'h7FFFFFF, 18'hF, j == 2, 1);
        check("4x4_a", a, 54'h1FEF);
        check("4x4_b", b, 54'h1FEF);
        check("4x4_lanes", out_lanes, 3);

        // 2x2 with stalled output: second word parks in HOLD, then drains back to back
        idle_step(1);
        for (int j = 0; j < 36; j++) step(1, 2'd3, 1, 1, 27'($urandom), 18'($urandom), 0, 0);
        check("2x2_hold_in_ready", in_ready, 0);
        check("2x2_hold_valid", out_valid, 1);
        idle_step(1);
        check("2x2_no_bubble", out_valid, 1);
        check("2x2_lanes", out_lanes, 18);
        idle_step(1);
        check("2x2_drained", out_valid, 0);

`ifdef SIMD_PACKER_TIMEOUT_EN
        for (int j = 0; j < 2; j++) step(1, 2'd1, 0, 0, 27'($urandom), 18'($urandom), 0, 1);
        k = 1;
        while (k <= 40) begin
            idle_step(1);
            if (out_valid) break;
            k++;
        end
        check("tmo_latency", k, 17);
        check("tmo_lanes", out_lanes, 2);
        idle_step(1);
`endif

        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom), 1'($urandom),
                 27'($urandom), 18'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < 4; i++) idle_step(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/simd_operand_packer.md
# simd_operand_packer

Operand-side producer for the multi-precision 27x18 / SIMD multiplier. It accepts a stream of narrow operand pairs over a valid/ready handshake and packs them into the 54-bit `a`/`b` lane layout the multiplier consumes in each mode. It emits one packed word per multiplication, with the mode and sign qualifiers latched alongside. It sits between the operand FIFOs and the multiplier input registers.

## Interface
Parameters:
- `TIMEOUT`, 16: idle cycles before a partial word is force-flushed. Used only with `SIMD_PACKER_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `mode`  in  2  00=27x18, 01=sum_9x9, 10=sum_4x4, 11=sum_2x2. Sampled on the first beat of a word.
- `a_sign`, `b_sign`  in  1 each  operand signedness, sampled with `mode`.
- `in_valid`  in  1  lane operand pair valid.
- `in_ready`  out  1  packer can accept a lane.
- `in_a`  in  27  A operand. Only the low 27/9/4/2 bits are used per mode.
- `in_b`  in  18  B operand. Only the low 18/9/4/2 bits are used per mode.
- `in_last`  in  1  close the current word after this lane.
- `out_valid`  out  1  packed word valid.
- `out_ready`  in  1  multiplier side accepts the word.
- `a`, `b`  out  54 each  packed operands.
- `out_mode`  out  2  mode latched for this word.
- `out_a_sign`, `out_b_sign`  out  1 each  latched signs.
- `out_lanes`  out  5  number of populated lanes in the word, 1..18.

## Operation
- Lanes per word (N):
  - 27x18 = 1
  - 9x9 = 6
  - 4x4 = 12
  - 2x2 = 18
- Slot k (0..5) occupies bits [9k+8:9k] of `a` and of `b`.
- Lane placement by mode:
  - 27x18: `a` = {27'b0, in_a}; `b` = {36'b0, in_b}.
  - 9x9: lane k goes to slot k.
  - 4x4: lane j goes to slot j/2 at offset 0 (j even) or offset 5 (j odd), 4 bits wide. Slot bit 4 is 0.
  - 2x2: lane j goes to slot j/3 at offset 0, 3 or 6 (j mod 3), 2 bits wide. Slot bits 2 and 5 are 0.
- Unpopulated lanes and guard bits are 0, so they contribute nothing to lane sums.
- Two storage stages: a pack register (lane counter `cnt`, 5 bits) and an output register.
- FSM:
  - **EMPTY**:
    - `in_ready`=1.
    - A beat latches `mode` and the signs, writes lane 0 and sets `cnt`=1.
    - If N=1 or `in_last`=1, the word is complete. Otherwise go to FILLING.
  - **FILLING**:
    - `in_ready`=1.
    - Each beat writes lane `cnt` and increments `cnt`.
    - The word completes when `cnt`+1==N or `in_last`=1.
    - `mode`/`a_sign`/`b_sign` are ignored in this state.
  - **HOLD**:
    - The word is complete but the output register is occupied. `in_ready`=0.
    - On the transfer edge, go to EMPTY.
- Transfer of a complete word:
  - Happens on the same edge it completes if the output register is empty, or is being emptied (`out_valid & out_ready`) on that edge. Otherwise the packer enters HOLD.
  - On transfer: `out_lanes` gets the lane count, the pack register clears to 0, and the FSM returns to EMPTY.
- The output register holds `a`, `b`, `out_*` stable while `out_valid & ~out_ready`.
- Reset (async, any state): every output and internal register is 0, FSM=EMPTY.
  - Outputs after reset: `out_valid`=0, `a`=`b`=0, `out_mode`=0, signs=0, `out_lanes`=0, `in_ready`=1.
  - A partial word in flight at reset is discarded.

## Timing
- Latency: the completing beat accepted at edge t gives `out_valid`=1 in the cycle after t.
- Throughput:
  - 1 lane per cycle sustained.
  - 27x18 mode: 1 word per cycle while `out_ready`=1.
- `in_ready` is a registered-state function only: 0 exactly in HOLD. It has no combinational path from `out_ready`.
- `out_valid` falls on the edge where `out_valid & out_ready` holds, unless a new word transfers on that same edge; then it stays 1 with the new data.
- Simultaneous output drain and pack completion: transfer occurs with no bubble.
- `in_last` with `cnt`+1==N is a normal completion; no extra word is produced.

## Configuration
- `SIMD_PACKER_TIMEOUT_EN` defined:
  - A counter increments each cycle in FILLING without an input beat and clears on any beat.
  - When it reaches `TIMEOUT`, the partial word completes as if `in_last` had arrived, and `out_lanes`=`cnt`.
  - The counter resets to 0 on `rst_n`.
- Undefined: no counter; a partial word waits indefinitely for `in_last` or for lane N.

## Test plan
- Reset mid-FILLING (9x9, 3 lanes loaded) -> `out_valid`=0, `a`=`b`=0, `in_ready`=1; the next 6 lanes produce a clean word with `out_lanes`=6.
- 27x18 stream, `in_a`=27'h7FFFFFF, `in_b`=18'h3FFFF, `out_ready`=1 -> one word per cycle, `a`=54'h0000007FFFFFF, `b`=54'h3FFFF, latency 1.
- 9x9 lanes `in_a`=1..6, `in_b`=9'h1FF -> `a`=slots {6,5,4,3,2,1}, `b`=all slots 9'h1FF, `out_mode`=01, `out_lanes`=6.
- 4x4 lanes 0..2 = 4'hF with `in_last` on lane 2 -> `a` bits[3:0]=F, [8:5]=F, [12:9]=F, all other bits 0, `out_lanes`=3.
- 2x2 with `out_ready`=0 -> first word held; the second 18 lanes fill, then `in_ready`=0 (HOLD); raising `out_ready` gives back-to-back `out_valid` with no bubble.
- With `SIMD_PACKER_TIMEOUT_EN`, `TIMEOUT`=16: 2 lanes in 9x9, then idle -> `out_valid` asserted 17 cycles after the last beat, `out_lanes`=2.
